// File: rtl/pkt_mem_responder_pkg.sv
// Shared definitions for the packet-memory load responder: size codes, FSM states,
// and the size-code to byte-count helper.
package pkt_mem_responder_pkg;

    localparam logic [1:0] BPF_W = 2'b00;
    localparam logic [1:0] BPF_H = 2'b01;
    localparam logic [1:0] BPF_B = 2'b10;
    localparam logic [1:0] BPF_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            BPF_W:   return 3'd4;
            BPF_H:   return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/pkt_mem_responder_byte_extract.sv
// Selects the requested big-endian bytes from one or two BRAM words and right-aligns them.
// Only word1[31:8] can ever contribute, since a load spans at most three bytes into word1.
module pkt_mem_responder_byte_extract
    import pkt_mem_responder_pkg::*;
(
    input  logic [31:0] word0_i,
    input  logic [23:0] word1_hi_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  sz_i,
    output logic [31:0] result_o
);

    logic [31:0] top;

    // top holds the four bytes starting at the requested lane, lowest address in the MSB
    always_comb begin
        case (lane_i)
            2'd0:    top = word0_i;
            2'd1:    top = {word0_i[23:0], word1_hi_i[23:16]};
            2'd2:    top = {word0_i[15:0], word1_hi_i[23:8]};
            default: top = {word0_i[7:0],  word1_hi_i};
        endcase
    end

    always_comb begin
        case (sz_i)
            BPF_W:   result_o = top;
            BPF_H:   result_o = {16'h0000, top[31:16]};
            default: result_o = {24'h000000, top[31:24]};
        endcase
    end

endmodule

// File: rtl/pkt_mem_responder.sv
// Packet-memory load responder: bounds-checks CPU loads, reads one or two BRAM words,
// returns zero-extended big-endian data, and aborts on an accept/reject verdict.
module pkt_mem_responder
    import pkt_mem_responder_pkg::*;
#(
    parameter int PKT_ADDR_WIDTH = 12,
    parameter bit PESS           = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [PKT_ADDR_WIDTH-1:0] addr,
    input  logic [1:0]                transfer_sz,
    input  logic [PKT_ADDR_WIDTH:0]   pkt_len,
    input  logic                      acc,
    input  logic                      rej,
    output logic                      rdy,
    output logic [31:0]               rd_data,
    output logic                      mem_vld,
    output logic                      oob,
    output logic                      done,
    output logic                      verdict,
    output logic                      bram_rd_en,
    output logic [PKT_ADDR_WIDTH-3:0] bram_addr,
    input  logic [31:0]               bram_rdata
);

    localparam int AW  = PKT_ADDR_WIDTH;
    localparam int AW1 = PKT_ADDR_WIDTH + 1;
    localparam int WW  = PKT_ADDR_WIDTH - 2;

    state_e          state_q, state_d;
    logic            span_q, oob_q, pend_oob_q, done_q, verdict_q;
    logic [1:0]      lane_q, sz_q;
    logic [WW-1:0]   waddr_q;
    logic [31:0]     word0_q, pend_q, rd_data_q;

    logic            abort, accept, req_oob, req_span, last_rd, completing, read_word1;
    logic [2:0]      nb;
    logic [AW1-1:0]  end_addr;
    logic [31:0]     ext_word0, ext_result, load_val, cur_data;
    logic            cur_oob;

    assign abort    = acc | rej;
    assign nb       = size_bytes(transfer_sz);
    assign end_addr = {1'b0, addr} + AW1'(nb) - AW1'(1);
    // end_addr[AW] catches spanning reads that would wrap past the last BRAM word
    assign req_oob  = (transfer_sz == BPF_X) | end_addr[AW] | (end_addr >= pkt_len);
    assign req_span = ({1'b0, addr[1:0]} + nb) > 3'd4;

    assign last_rd    = ((state_q == ST_RD0) && (oob_q || !span_q)) || (state_q == ST_RD1);
    assign completing = PESS ? (state_q == ST_OUT) : last_rd;
    // The completion cycle behaves as idle so a new load can be accepted back-to-back
    assign rdy        = (state_q == ST_IDLE) || completing;
    assign accept     = rst & rdy & rd_en & ~abort;
    assign read_word1 = (state_q == ST_RD0) && span_q && !oob_q && !abort;

    always_comb begin
        state_d    = state_q;
        bram_rd_en = 1'b0;
        bram_addr  = '0;
        if (accept && !req_oob) begin
            bram_rd_en = 1'b1;
            bram_addr  = addr[AW-1:2];
        end else if (read_word1) begin
            bram_rd_en = 1'b1;
            bram_addr  = waddr_q + WW'(1);
        end
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD0;
            ST_RD0:  state_d = (oob_q || !span_q) ? (PESS ? ST_OUT : ST_IDLE) : ST_RD1;
            ST_RD1:  state_d = PESS ? ST_OUT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (completing && accept) state_d = ST_RD0;
        if (abort) state_d = ST_IDLE;
    end

    assign ext_word0 = (state_q == ST_RD1) ? word0_q : bram_rdata;

    pkt_mem_responder_byte_extract u_extract (
        .word0_i    (ext_word0),
        .word1_hi_i (bram_rdata[31:8]),
        .lane_i     (lane_q),
        .sz_i       (sz_q),
        .result_o   (ext_result)
    );

    assign load_val = oob_q ? 32'h0 : ext_result;
    assign cur_data = PESS ? pend_q : load_val;
    assign cur_oob  = PESS ? pend_oob_q : oob_q;

    assign mem_vld  = completing & ~abort;
    assign oob      = mem_vld & cur_oob;
    assign rd_data  = mem_vld ? cur_data : rd_data_q;
    assign done     = done_q;
    assign verdict  = verdict_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            span_q     <= 1'b0;
            oob_q      <= 1'b0;
            pend_oob_q <= 1'b0;
            done_q     <= 1'b0;
            verdict_q  <= 1'b0;
            lane_q     <= 2'd0;
            sz_q       <= BPF_W;
            waddr_q    <= '0;
            word0_q    <= 32'h0;
            pend_q     <= 32'h0;
            rd_data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            done_q  <= abort;
            if (abort) verdict_q <= acc & ~rej;
            if (accept) begin
                lane_q  <= addr[1:0];
                sz_q    <= transfer_sz;
                oob_q   <= req_oob;
                span_q  <= req_span;
                waddr_q <= addr[AW-1:2];
            end
            if ((state_q == ST_RD0) && span_q) word0_q <= bram_rdata;
            if (last_rd) begin
                pend_q     <= load_val;
                pend_oob_q <= oob_q;
            end
            if (mem_vld) rd_data_q <= cur_data;
        end
    end

endmodule

// File: tb/tb_pkt_mem_responder.sv
// Directed bench: a PESS=0 and a PESS=1 responder side by side, each with its own BRAM model.
module tb_pkt_mem_responder;
    import pkt_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en0 = 1'b0, rd_en1 = 1'b0;
    logic [11:0] addr = '0;
    logic [1:0]  tsz = BPF_W;
    logic [12:0] pkt_len = 13'd8;
    logic        acc = 1'b0, rej = 1'b0;

    logic        rdy0, rdy1, vld0, vld1, oob0, oob1, done0, done1, verd0, verd1;
    logic        bre0, bre1;
    logic [9:0]  bra0, bra1;
    logic [31:0] rdat0, rdat1, brd0 = '0, brd1 = '0;

    logic [31:0] mem [0:1023];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int t_req;
    int vld_cnt0 = 0, vld_cnt1 = 0, br_cnt0 = 0, br_cnt1 = 0, dn_cnt0 = 0, dn_cnt1 = 0;
    int vld_cyc0 [0:63];
    int vld_cyc1 [0:63];
    logic [31:0] vld_dat0 [0:63];
    logic [31:0] vld_dat1 [0:63];
    logic        vld_oob0 [0:63];
    logic        vld_oob1 [0:63];
    int dn_cyc0 = 0, dn_cyc1 = 0;
    logic dn_v0 = 1'b0, dn_v1 = 1'b0;
    int b_vld0, b_vld1, b_br0, b_br1, b_dn0, b_dn1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pkt_mem_responder #(.PKT_ADDR_WIDTH(12), .PESS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en0), .addr(addr), .transfer_sz(tsz),
        .pkt_len(pkt_len), .acc(acc), .rej(rej), .rdy(rdy0), .rd_data(rdat0),
        .mem_vld(vld0), .oob(oob0), .done(done0), .verdict(verd0),
        .bram_rd_en(bre0), .bram_addr(bra0), .bram_rdata(brd0)
    );

    pkt_mem_responder #(.PKT_ADDR_WIDTH(12), .PESS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en1), .addr(addr), .transfer_sz(tsz),
        .pkt_len(pkt_len), .acc(acc), .rej(rej), .rdy(rdy1), .rd_data(rdat1),
        .mem_vld(vld1), .oob(oob1), .done(done1), .verdict(verd1),
        .bram_rd_en(bre1), .bram_addr(bra1), .bram_rdata(brd1)
    );

    always @(posedge clk) begin
        if (bre0) brd0 <= mem[bra0];
        if (bre1) brd1 <= mem[bra1];
    end

    always @(negedge clk) begin
        if (vld0) begin
            vld_cyc0[vld_cnt0 % 64] = cyc;
            vld_dat0[vld_cnt0 % 64] = rdat0;
            vld_oob0[vld_cnt0 % 64] = oob0;
            vld_cnt0++;
        end
        if (vld1) begin
            vld_cyc1[vld_cnt1 % 64] = cyc;
            vld_dat1[vld_cnt1 % 64] = rdat1;
            vld_oob1[vld_cnt1 % 64] = oob1;
            vld_cnt1++;
        end
        if (bre0) br_cnt0++;
        if (bre1) br_cnt1++;
        if (done0) begin dn_cnt0++; dn_cyc0 = cyc; dn_v0 = verd0; end
        if (done1) begin dn_cnt1++; dn_cyc1 = cyc; dn_v1 = verd1; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_vld0 = vld_cnt0; b_vld1 = vld_cnt1;
        b_br0  = br_cnt0;  b_br1  = br_cnt1;
        b_dn0  = dn_cnt0;  b_dn1  = dn_cnt1;
    endtask

    task automatic load(input logic [11:0] a, input logic [1:0] sz);
        snap();
        @(posedge clk); #1;
        rd_en0 = 1'b1; rd_en1 = 1'b1; addr = a; tsz = sz; t_req = cyc;
        @(posedge clk); #1;
        rd_en0 = 1'b0; rd_en1 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_load(input string tag, input int lat, input logic [31:0] dat,
                              input logic o, input int reads);
        int i0, i1;
        i0 = b_vld0 % 64; i1 = b_vld1 % 64;
        check({tag, " vlds/d0"}, vld_cnt0 - b_vld0, 1);
        check({tag, " vlds/d1"}, vld_cnt1 - b_vld1, 1);
        check({tag, " lat/d0"}, vld_cyc0[i0] - t_req, lat);
        check({tag, " lat/d1"}, vld_cyc1[i1] - t_req, lat + 1);
        check({tag, " data/d0"}, vld_dat0[i0], dat);
        check({tag, " data/d1"}, vld_dat1[i1], dat);
        check({tag, " oob/d0"}, {31'b0, vld_oob0[i0]}, {31'b0, o});
        check({tag, " oob/d1"}, {31'b0, vld_oob1[i1]}, {31'b0, o});
        check({tag, " reads/d0"}, br_cnt0 - b_br0, reads);
        check({tag, " reads/d1"}, br_cnt1 - b_br1, reads);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'hAABBCCDD;
        mem[1] = 32'h11223344;

        // reset held with a request pending: nothing may leave the block
        rd_en0 = 1'b1; rd_en1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst rdy0", {31'b0, rdy0}, 1);
        check("rst rdy1", {31'b0, rdy1}, 1);
        check("rst rd_data0", rdat0, 0);
        check("rst vld0", {31'b0, vld0}, 0);
        check("rst done0", {31'b0, done0}, 0);
        check("rst verdict0", {31'b0, verd0}, 0);
        check("rst bram_en0", {31'b0, bre0}, 0);
        check("rst bram_en1", {31'b0, bre1}, 0);
        check("rst bram_addr0", {22'b0, bra0}, 0);
        rd_en0 = 1'b0; rd_en1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        load(12'd1, BPF_B);
        check_load("B@1", 1, 32'h000000BB, 1'b0, 1);
        check("hold rd_data0", rdat0, 32'h000000BB);
        check("hold rd_data1", rdat1, 32'h000000BB);
        check("idle oob0", {31'b0, oob0}, 0);

        load(12'd2, BPF_W);
        check_load("W@2", 2, 32'hCCDD1122, 1'b0, 2);

        load(12'd3, BPF_H);
        check_load("H@3", 2, 32'h0000DD11, 1'b0, 2);

        load(12'd4, BPF_W);
        check_load("W@4", 1, 32'h11223344, 1'b0, 1);

        load(12'd5, BPF_W);
        check_load("W@5 oob", 1, 32'h0, 1'b1, 0);

        load(12'd0, BPF_X);
        check_load("sz11", 1, 32'h0, 1'b1, 0);

        // last word spanning into a nonexistent word must be OOB even with a huge pkt_len
        pkt_len = 13'h1FFF;
        load(12'hFFE, BPF_W);
        check_load("wrap", 1, 32'h0, 1'b1, 0);
        pkt_len = 13'd8;

        // back-to-back on the PESS=0 instance: second request in the mem_vld cycle
        snap();
        @(posedge clk); #1;
        rd_en0 = 1'b1; addr = 12'd0; tsz = BPF_B; t_req = cyc;
        @(posedge clk); #1;
        addr = 12'd7;
        @(posedge clk); #1;
        rd_en0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("b2b vlds", vld_cnt0 - b_vld0, 2);
        check("b2b lat1", vld_cyc0[b_vld0 % 64] - t_req, 1);
        check("b2b data1", vld_dat0[b_vld0 % 64], 32'h000000AA);
        check("b2b lat2", vld_cyc0[(b_vld0 + 1) % 64] - t_req, 2);
        check("b2b data2", vld_dat0[(b_vld0 + 1) % 64], 32'h00000044);
        check("b2b reads", br_cnt0 - b_br0, 2);

        // spanning load rejected one cycle after acceptance
        snap();
        @(posedge clk); #1;
        rd_en0 = 1'b1; rd_en1 = 1'b1; addr = 12'd2; tsz = BPF_W; t_req = cyc;
        @(posedge clk); #1;
        rd_en0 = 1'b0; rd_en1 = 1'b0; rej = 1'b1;
        @(posedge clk); #1;
        rej = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rej vlds/d0", vld_cnt0 - b_vld0, 0);
        check("rej vlds/d1", vld_cnt1 - b_vld1, 0);
        check("rej reads/d0", br_cnt0 - b_br0, 1);
        check("rej dones/d0", dn_cnt0 - b_dn0, 1);
        check("rej dones/d1", dn_cnt1 - b_dn1, 1);
        check("rej done cyc/d0", dn_cyc0 - t_req, 2);
        check("rej verdict/d0", {31'b0, dn_v0}, 0);
        check("rej verdict/d1", {31'b0, dn_v1}, 0);
        check("rej rdy/d1", {31'b0, rdy1}, 1);

        // acc alone accepts; acc with rej rejects
        @(posedge clk); #1;
        acc = 1'b1; t_req = cyc;
        @(posedge clk); #1;
        acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("acc done cyc", dn_cyc0 - t_req, 1);
        check("acc verdict/d0", {31'b0, dn_v0}, 1);
        check("acc verdict/d1", {31'b0, dn_v1}, 1);
        check("verdict held", {31'b0, verd0}, 1);
        snap();
        @(posedge clk); #1;
        acc = 1'b1; rej = 1'b1;
        @(posedge clk); #1;
        acc = 1'b0; rej = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("accrej dones", dn_cnt0 - b_dn0, 1);
        check("accrej verdict", {31'b0, dn_v0}, 0);

        // reset asserted while the PESS=1 instance is waiting on word1
        snap();
        @(posedge clk); #1;
        rd_en1 = 1'b1; addr = 12'd2; tsz = BPF_W;
        @(posedge clk); #1;
        rd_en1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rstmid vlds/d1", vld_cnt1 - b_vld1, 0);
        check("rstmid rdy/d1", {31'b0, rdy1}, 1);
        check("rstmid rd_data/d1", rdat1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
